// File: rtl/pwm_duty_ctrl.sv
// Duty-cycle controller: shadows duty requests and loads the PWM compare value only at phase wraps.
// Optional per-period ramping toward the target is enabled by defining PWM_DUTY_CTRL_RAMP_EN.
module pwm_duty_ctrl #(
  parameter int N      = 14,
  parameter int M      = 12,
  parameter int STEP_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N-1:0]      phase,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [M-1:0]      wr_duty,
  input  logic [STEP_W-1:0] wr_step,
  output logic [M-1:0]      mod,
  output logic              busy,
  output logic              wrap_pulse
);

`ifdef PWM_DUTY_CTRL_RAMP_EN
  typedef enum logic [1:0] {IDLE, PENDING, RAMP} state_t;
`else
  typedef enum logic [1:0] {IDLE, PENDING} state_t;
`endif

  state_t         state, state_nxt;
  logic [N-1:0]   phase_q;
  logic [M-1:0]   target;
  logic [M-1:0]   mod_nxt;
  logic           wrap;
  logic           accept;

  // A wrap is a drop of phase below its registered copy, which clears to zero on reset
  assign wrap   = (phase < phase_q);
  assign accept = (state == IDLE) && wr_valid;

`ifdef PWM_DUTY_CTRL_RAMP_EN
  logic [STEP_W-1:0] step;
  logic signed [M:0] diff;
  logic [M:0]        mag;
  logic [M-1:0]      ramp_mod;

  // One slew step toward target; snaps to target once within one step, so it never overshoots
  always_comb begin
    diff = signed'({1'b0, target}) - signed'({1'b0, mod});
    mag  = diff[M] ? unsigned'(-diff) : unsigned'(diff);
    if (mag <= {{(M+1-STEP_W){1'b0}}, step})
      ramp_mod = target;
    else if (diff[M])
      ramp_mod = mod - {{(M-STEP_W){1'b0}}, step};
    else
      ramp_mod = mod + {{(M-STEP_W){1'b0}}, step};
  end
`else
  logic unused_wr_step;
  assign unused_wr_step = ^wr_step;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      phase_q    <= '0;
      target     <= '0;
      mod        <= '0;
      wrap_pulse <= 1'b0;
`ifdef PWM_DUTY_CTRL_RAMP_EN
      step       <= '0;
`endif
    end else begin
      state      <= state_nxt;
      phase_q    <= phase;
      mod        <= mod_nxt;
      wrap_pulse <= wrap;
      if (accept) begin
        target <= wr_duty;
`ifdef PWM_DUTY_CTRL_RAMP_EN
        step   <= wr_step;
`endif
      end
    end
  end

  // An accept that coincides with a wrap only reaches PENDING, so that wrap is not applied
  always_comb begin
    state_nxt = state;
    mod_nxt   = mod;
    unique case (state)
      IDLE: begin
        if (wr_valid)
          state_nxt = PENDING;
      end
      PENDING: begin
        if (wrap) begin
`ifdef PWM_DUTY_CTRL_RAMP_EN
          if (step == '0) begin
            mod_nxt   = target;
            state_nxt = IDLE;
          end else begin
            mod_nxt   = ramp_mod;
            state_nxt = (ramp_mod == target) ? IDLE : RAMP;
          end
`else
          mod_nxt   = target;
          state_nxt = IDLE;
`endif
        end
      end
`ifdef PWM_DUTY_CTRL_RAMP_EN
      RAMP: begin
        if (wrap) begin
          mod_nxt = ramp_mod;
          if (ramp_mod == target)
            state_nxt = IDLE;
        end
      end
`endif
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    wr_ready = (state == IDLE);
    busy     = (state != IDLE);
  end

endmodule

// File: tb/tb_pwm_duty_ctrl.sv
// Self-checking bench for pwm_duty_ctrl: directed scenarios plus randomized traffic against a
// request-level reference model; follows PWM_DUTY_CTRL_RAMP_EN for the ramp scenarios.
module tb_pwm_duty_ctrl;
  localparam int N      = 14;
  localparam int M      = 12;
  localparam int STEP_W = 8;
`ifdef PWM_DUTY_CTRL_RAMP_EN
  localparam bit RAMP_EN = 1'b1;
`else
  localparam bit RAMP_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [N-1:0]      phase = '0;
  logic              wr_valid = 1'b0;
  logic [M-1:0]      wr_duty = '0;
  logic [STEP_W-1:0] wr_step = '0;
  logic              wr_ready;
  logic [M-1:0]      mod;
  logic              busy;
  logic              wrap_pulse;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pwm_duty_ctrl #(.N(N), .M(M), .STEP_W(STEP_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .phase     (phase),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_duty   (wr_duty),
    .wr_step   (wr_step),
    .mod       (mod),
    .busy      (busy),
    .wrap_pulse(wrap_pulse)
  );

  // Reference model: one outstanding request that moves mod toward its target on each wrap
  int m_mod, m_target, m_step, m_prev;
  bit m_have, m_pulse, m_acc, m_seen, m_wrap;

  function automatic int toward(input int cur, input int tgt, input int stp);
    int d;
    d = tgt - cur;
    if (!RAMP_EN || stp == 0 || (d <= stp && d >= -stp))
      return tgt;
    return (d > 0) ? cur + stp : cur - stp;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_mod = 0; m_target = 0; m_step = 0; m_prev = 0;
      m_have = 0; m_pulse = 0; m_acc = 0; m_seen = 1;
    end else begin
      m_wrap = (int'(phase) < m_prev);
      m_acc  = 0;
      if (m_have && m_wrap) begin
        m_mod = toward(m_mod, m_target, m_step);
        if (m_mod == m_target) m_have = 0;
      end else if (!m_have && wr_valid) begin
        m_target = int'(wr_duty);
        m_step   = int'(wr_step);
        m_have   = 1;
        m_acc    = 1;
      end
      m_pulse = m_wrap;
      m_prev  = int'(phase);
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (m_seen) begin
      checkOutput("model.mod", 32'(mod), 32'(m_mod));
      checkOutput("model.wr_ready", 32'(wr_ready), 32'(!m_have));
      checkOutput("model.busy", 32'(busy), 32'(m_have));
      checkOutput("model.wrap_pulse", 32'(wrap_pulse), 32'(m_pulse));
    end
  end

  task automatic applyStimulus(input int ph, input bit v, input int d, input int s);
    phase    = N'(ph);
    wr_valid = v;
    wr_duty  = M'(d);
    wr_step  = STEP_W'(s);
    @(posedge clk);
    #2;
  endtask

  task automatic doWrap();
    applyStimulus(14'h3FF0, 1'b0, 0, 0);
    applyStimulus(14'h0010, 1'b0, 0, 0);
  endtask

  task automatic doReset();
    rst = 1'b1;
    applyStimulus(int'($urandom_range(0, 16383)), 1'b0, 0, 0);
    applyStimulus(int'($urandom_range(0, 16383)), 1'b0, 0, 0);
    rst = 1'b0;
  endtask

  initial begin
    int ph, inc, s, nd, ns;
    bit nv;

    doReset();
    checkOutput("reset.mod", 32'(mod), 32'h0);
    checkOutput("reset.wr_ready", 32'(wr_ready), 32'h1);
    checkOutput("reset.busy", 32'(busy), 32'h0);
    checkOutput("reset.wrap_pulse", 32'(wrap_pulse), 32'h0);

    applyStimulus(14'h1000, 1'b1, 12'h800, 0);
    checkOutput("load.accept_busy", 32'(busy), 32'h1);
    checkOutput("load.hold_mod", 32'(mod), 32'h0);
    applyStimulus(14'h3FF0, 1'b0, 12'h800, 0);
    checkOutput("load.prewrap_mod", 32'(mod), 32'h0);
    applyStimulus(14'h0010, 1'b0, 12'h800, 0);
    checkOutput("load.mod", 32'(mod), 32'h800);
    checkOutput("load.wrap_pulse", 32'(wrap_pulse), 32'h1);
    checkOutput("load.busy", 32'(busy), 32'h0);
    checkOutput("load.wr_ready", 32'(wr_ready), 32'h1);
    applyStimulus(14'h0100, 1'b0, 0, 0);
    checkOutput("load.pulse_drop", 32'(wrap_pulse), 32'h0);

    applyStimulus(14'h1000, 1'b1, 12'h300, 0);
    applyStimulus(14'h3FF0, 1'b1, 12'h200, 0);
    checkOutput("hs.busy_hold_mod", 32'(mod), 32'h800);
    applyStimulus(14'h0010, 1'b1, 12'h200, 0);
    checkOutput("hs.first_done", 32'(mod), 32'h300);
    checkOutput("hs.ready_back", 32'(wr_ready), 32'h1);
    applyStimulus(14'h0100, 1'b1, 12'h200, 0);
    checkOutput("hs.second_accepted", 32'(busy), 32'h1);
    doWrap();
    checkOutput("hs.second_done", 32'(mod), 32'h200);

    applyStimulus(14'h3FF0, 1'b0, 0, 0);
    applyStimulus(14'h0010, 1'b1, 12'h123, 0);
    checkOutput("coll.mod_unchanged", 32'(mod), 32'h200);
    checkOutput("coll.busy", 32'(busy), 32'h1);
    checkOutput("coll.wrap_pulse", 32'(wrap_pulse), 32'h1);
    doWrap();
    checkOutput("coll.applied_next", 32'(mod), 32'h123);

    if (RAMP_EN) begin
      doReset();
      applyStimulus(14'h1000, 1'b1, 12'h100, 8'h40);
      for (int k = 1; k <= 4; k++) begin
        doWrap();
        checkOutput("ramp.step_mod", 32'(mod), 32'(k * 'h40));
      end
      checkOutput("ramp.done_busy", 32'(busy), 32'h0);
      applyStimulus(14'h1000, 1'b1, 12'h0F0, 8'h40);
      doWrap();
      checkOutput("ramp.no_overshoot", 32'(mod), 32'h0F0);
      checkOutput("ramp.no_overshoot_idle", 32'(busy), 32'h0);

      doReset();
      applyStimulus(14'h1000, 1'b1, 12'h100, 8'h40);
      doWrap();
      doWrap();
      checkOutput("midrst.mod_before", 32'(mod), 32'h080);
      rst = 1'b1;
      applyStimulus(14'h2000, 1'b0, 0, 0);
      rst = 1'b0;
      checkOutput("midrst.mod", 32'(mod), 32'h0);
      checkOutput("midrst.busy", 32'(busy), 32'h0);
      doWrap();
      checkOutput("midrst.no_step", 32'(mod), 32'h0);
    end

    ph = int'(phase);
    for (int i = 0; i < 4000; i++) begin
      inc = int'($urandom_range(300, 3000));
      ph  = (ph + inc) % (1 << N);
      rst = ($urandom_range(0, 599) == 0);
      nv = wr_valid; nd = int'(wr_duty); ns = int'(wr_step);
      if (wr_valid && m_acc) begin
        nv = 1'b0;
      end else if (!wr_valid && $urandom_range(0, 3) == 0) begin
        nv = 1'b1;
        nd = int'($urandom_range(0, (1 << M) - 1));
        s  = int'($urandom_range(0, 255));
        ns = (s < 64) ? 0 : s;
      end
      applyStimulus(ph, nv, nd, ns);
    end
    rst = 1'b0;
    applyStimulus(ph, 1'b0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
